// File: rtl/pi_code_seq_if.sv
// -----------------------------------------------------------------------------
// pi_code_seq_if
// Signal bundle between the phase-code sequencer and its environment.
//
// Handshake: a manual load transfers on a rising clk edge where
// load_vld && load_rdy are both high. load_vld may be raised at any time and
// must hold load_code stable while waiting; load_rdy does not depend on
// load_vld.
//
// Signals:
//   en        tracking enable
//   up, dn    phase-detector early/late votes, one per cycle
//   load_vld  manual load request
//   load_code manual code {quad, ctl}
//   load_rdy  sequencer can accept a load this cycle
//   ctl       interpolator weight code
//   quad      clock-pair select
//   upd       one-cycle pulse after the code changed
//   busy      high while the interpolator is settling
//   lock      lock indicator
//   dbg_state current sequencer state (0 TRACK, 1 SETTLE, 2 FREEZE)
//
// Modports: master = environment / bench, slave = sequencer.
// -----------------------------------------------------------------------------
interface pi_code_seq_if #(
  parameter int Nbit = 6,
  parameter int Nq   = 2
);
  logic              en;
  logic              up;
  logic              dn;
  logic              load_vld;
  logic [Nq+Nbit-1:0] load_code;
  logic              load_rdy;
  logic [Nbit-1:0]   ctl;
  logic [Nq-1:0]     quad;
  logic              upd;
  logic              busy;
  logic              lock;
  logic [1:0]        dbg_state;

  modport master (
    output en, up, dn, load_vld, load_code,
    input  load_rdy, ctl, quad, upd, busy, lock, dbg_state
  );

  modport slave (
    input  en, up, dn, load_vld, load_code,
    output load_rdy, ctl, quad, upd, busy, lock, dbg_state
  );
endinterface

// File: rtl/pi_code_seq.sv
// -----------------------------------------------------------------------------
// pi_code_seq
// Phase-code sequencer for the digitally-controlled phase interpolator.
// Filters bang-bang up/dn votes through a signed accumulator and steps the
// combined {quad, ctl} code by one whenever the net vote reaches +/-THR.
// After every code change the sequencer sits in SETTLE for HOLD cycles so the
// interpolator output settles before the next step. A manual code can be
// loaded over a valid/ready handshake.
//
// Ports:
//   clk  sequencer clock
//   rst  asynchronous, active-high reset
//   bus  pi_code_seq_if.slave (votes, enable, load handshake, code outputs,
//        upd/busy/lock status, debug state)
//
// Optional feature (macro PI_CODE_SEQ_LOCK_DET_EN): lock detector. Counts
// consecutive threshold steps that alternate direction; lock rises when the
// count reaches LOCK_N. Without the macro lock is constant 0.
// -----------------------------------------------------------------------------
module pi_code_seq #(
  parameter int               Nbit     = 6,
  parameter int               Nq       = 2,
  parameter int               THR      = 4,
  parameter int               HOLD     = 8,
  parameter logic [Nq+Nbit-1:0] RST_CODE = '0,
  parameter int               LOCK_N   = 8
) (
  input  logic            clk,
  input  logic            rst,
  pi_code_seq_if.slave    bus
);

  localparam int W = Nq + Nbit;
  localparam logic signed [7:0] THR_S  = 8'(THR);
  localparam logic [7:0]        HOLD_M1 = 8'(HOLD - 1);

  typedef enum logic [1:0] {
    TRACK  = 2'd0,
    SETTLE = 2'd1,
    FREEZE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic signed [7:0] r_acc, w_acc_nxt, w_acc_sum, w_vote;
  logic [W-1:0]      r_code, w_code_nxt;
  logic [7:0]        r_hcnt, w_hcnt_nxt;
  logic              r_upd;
  logic              w_load_rdy, w_load_hs;
  logic              w_track_vote, w_step_up, w_step_dn;

  // load_rdy is forced low while reset is asserted, not just from state.
  assign w_load_rdy = (r_state != SETTLE) && !rst;
  assign w_load_hs  = bus.load_vld && w_load_rdy;

  always_comb begin
    w_vote = 8'sd0;
    if (bus.up && !bus.dn)      w_vote = 8'sd1;
    else if (bus.dn && !bus.up) w_vote = -8'sd1;
  end

  assign w_acc_sum    = r_acc + w_vote;
  // Votes count only in TRACK with tracking enabled and no load winning.
  assign w_track_vote = (r_state == TRACK) && bus.en && !w_load_hs;
  assign w_step_up    = w_track_vote && (w_acc_sum == THR_S);
  assign w_step_dn    = w_track_vote && (w_acc_sum == -THR_S);

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_code_nxt  = r_code;
    w_hcnt_nxt  = r_hcnt;
    case (r_state)
      TRACK: begin
        if (w_load_hs) begin
          w_code_nxt  = bus.load_code;
          w_acc_nxt   = 8'sd0;
          w_hcnt_nxt  = HOLD_M1;
          w_state_nxt = SETTLE;
        end else if (!bus.en) begin
          w_acc_nxt   = 8'sd0;
          w_state_nxt = FREEZE;
        end else if (w_step_up || w_step_dn) begin
          // {quad, ctl} is one modular counter: ctl carries/borrows into quad.
          w_code_nxt  = w_step_up ? r_code + W'(1) : r_code - W'(1);
          w_acc_nxt   = 8'sd0;
          w_hcnt_nxt  = HOLD_M1;
          w_state_nxt = SETTLE;
        end else begin
          w_acc_nxt   = w_acc_sum;
        end
      end
      SETTLE: begin
        w_acc_nxt = 8'sd0;
        if (r_hcnt == 8'd0) begin
          // A drop of en during SETTLE takes effect once settling is done.
          w_state_nxt = bus.en ? TRACK : FREEZE;
        end else begin
          w_hcnt_nxt = r_hcnt - 8'd1;
        end
      end
      FREEZE: begin
        w_acc_nxt = 8'sd0;
        if (w_load_hs) begin
          w_code_nxt  = bus.load_code;
          w_hcnt_nxt  = HOLD_M1;
          w_state_nxt = SETTLE;
        end else if (bus.en) begin
          w_state_nxt = TRACK;
        end
      end
      default: begin
        w_state_nxt = TRACK;
        w_acc_nxt   = 8'sd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= TRACK;
      r_acc   <= 8'sd0;
      r_code  <= RST_CODE;
      r_hcnt  <= 8'd0;
      r_upd   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_code  <= w_code_nxt;
      r_hcnt  <= w_hcnt_nxt;
      // Pulse only on a real value change, so an identical load is silent.
      r_upd   <= (w_code_nxt != r_code);
    end
  end

  assign bus.ctl       = r_code[Nbit-1:0];
  assign bus.quad      = r_code[W-1:Nbit];
  assign bus.upd       = r_upd;
  assign bus.busy      = (r_state == SETTLE);
  assign bus.load_rdy  = w_load_rdy;
  assign bus.dbg_state = r_state;

`ifdef PI_CODE_SEQ_LOCK_DET_EN
  localparam int LW = $clog2(LOCK_N + 1);

  logic [LW-1:0] r_lcnt, w_lcnt_nxt;
  logic          r_prev_vld, r_prev_up, r_lock;
  logic          w_prev_vld_nxt, w_prev_up_nxt;

  always_comb begin
    w_lcnt_nxt     = r_lcnt;
    w_prev_vld_nxt = r_prev_vld;
    w_prev_up_nxt  = r_prev_up;
    if (w_load_hs || (r_state == FREEZE) || (w_state_nxt == FREEZE)) begin
      w_lcnt_nxt     = '0;
      w_prev_vld_nxt = 1'b0;
      w_prev_up_nxt  = 1'b0;
    end else if (w_step_up || w_step_dn) begin
      // The first step after a clear only records its direction.
      if (r_prev_vld) begin
        if (r_prev_up != w_step_up) begin
          if (r_lcnt != LW'(LOCK_N)) w_lcnt_nxt = r_lcnt + LW'(1);
        end else begin
          w_lcnt_nxt = '0;
        end
      end
      w_prev_vld_nxt = 1'b1;
      w_prev_up_nxt  = w_step_up;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lcnt     <= '0;
      r_prev_vld <= 1'b0;
      r_prev_up  <= 1'b0;
      r_lock     <= 1'b0;
    end else begin
      r_lcnt     <= w_lcnt_nxt;
      r_prev_vld <= w_prev_vld_nxt;
      r_prev_up  <= w_prev_up_nxt;
      r_lock     <= (w_lcnt_nxt == LW'(LOCK_N));
    end
  end

  assign bus.lock = r_lock;
`else
  // No detector: LOCK_N is only referenced to keep it part of the interface;
  // the expression is constant 0 for any legal LOCK_N.
  assign bus.lock = (LOCK_N < 0);
`endif

endmodule
